// File: rtl/dft_stage_sched.sv
// Sequencer for the shared 8-to-4 DFT butterfly stage: steps N_GRP groups of one
// frame through the stage, drives the twiddle set address and owns the output register handshake.
module dft_stage_sched #(
  parameter int unsigned N_GRP   = 4,
  parameter int unsigned GRP_W   = $clog2(N_GRP),
  parameter int unsigned TW_AW   = 4,
  parameter int unsigned TW_STEP = 2,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [TW_AW-1:0]  tw_addr,
  output logic              cap_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GRP_W-1:0]  out_grp,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_start,
  input  logic              err_clr
);

  // Group counter must reach N_GRP, one past the last group index.
  localparam int unsigned CNT_W = $clog2(N_GRP + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  grp_cnt_q, grp_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [GRP_W-1:0]  out_grp_q, out_grp_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;

  logic accept;
  logic xfer;
  logic last_grp;

  // Stage-input handshake and twiddle addressing, straight from registered state.
  always_comb begin
    in_ready = (state_q == S_RUN) && (grp_cnt_q < CNT_W'(N_GRP)) &&
               (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    cap_en   = accept;
    xfer     = out_valid_q && out_ready;
    last_grp = (grp_cnt_q == CNT_W'(N_GRP - 1));
    tw_addr  = '0;
    if (state_q == S_RUN) begin
      tw_addr = TW_AW'(32'(grp_cnt_q) * TW_STEP);
    end
  end

  // Next-state and output-register logic; abort overrides everything but the error flag.
  always_comb begin
    state_d     = state_q;
    grp_cnt_d   = grp_cnt_q;
    out_valid_d = out_valid_q;
    out_grp_d   = out_grp_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end
    if (start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    if (abort) begin
      state_d     = S_IDLE;
      grp_cnt_d   = '0;
      out_valid_d = 1'b0;
      out_grp_d   = '0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            grp_cnt_d = '0;
          end
        end
        S_RUN: begin
          // A reload on accept also covers a simultaneous downstream transfer.
          if (accept) begin
            out_valid_d = 1'b1;
            out_grp_d   = GRP_W'(grp_cnt_q);
            out_last_d  = last_grp;
            grp_cnt_d   = grp_cnt_q + CNT_W'(1);
            if (last_grp) begin
              state_d = S_DRAIN;
            end
          end else if (xfer) begin
            out_valid_d = 1'b0;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          state_d     = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grp_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_grp_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_cnt_q   <= grp_cnt_d;
      out_valid_q <= out_valid_d;
      out_grp_q   <= out_grp_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_grp   = out_grp_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign err_start = err_q;

endmodule

// File: tb/tb_dft_stage_sched.sv
// Directed bench for dft_stage_sched: scoreboarded output groups plus cycle-level checks.
// A second instance with a 2-bit frame counter shares all inputs to exercise the wrap.
module tb_dft_stage_sched;

  logic clk;
  logic rst_n;
  logic start, abort, in_valid, out_ready, err_clr;

  logic       in_ready, cap_en, out_valid, out_last, busy, done, err_start;
  logic [3:0] tw_addr;
  logic [1:0] out_grp;
  logic [15:0] frame_cnt;

  logic       in_ready2, cap_en2, out_valid2, out_last2, busy2, done2, err_start2;
  logic [3:0] tw_addr2;
  logic [1:0] out_grp2;
  logic [1:0] frame_cnt2;

  int n_chk = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  dft_stage_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .tw_addr(tw_addr), .cap_en(cap_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp), .out_last(out_last),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .err_start(err_start), .err_clr(err_clr)
  );

  dft_stage_sched #(.FCNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready2), .tw_addr(tw_addr2), .cap_en(cap_en2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_grp(out_grp2), .out_last(out_last2),
    .busy(busy2), .done(done2), .frame_cnt(frame_cnt2), .err_start(err_start2), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int g = 0; g < 4; g++) exp_q.push_back({2'(g), (g == 3)});
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: every downstream transfer must match the next expected group.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_empty: got grp %0d last %0b with nothing expected", out_grp, out_last);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", 32'({out_grp, out_last}), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_grp", 32'(out_grp), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_tw_addr", 32'(tw_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_start", 32'(err_start), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full-throughput frame.
    @(negedge clk); start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; push_frame();
    @(negedge clk); start = 1'b0; #1;
    chk("run_busy", 32'(busy), 32'd1);
    for (int g = 0; g < 4; g++) begin
      chk("run_tw_addr", 32'(tw_addr), 32'(2 * g));
      chk("run_cap_en", 32'(cap_en), 32'd1);
      @(negedge clk); #1;
    end
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_tw_addr", 32'(tw_addr), 32'd0);
    chk("drain_out_last", 32'(out_last), 32'd1);
    @(negedge clk); #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_cap_en", 32'(cap_en), 32'd0);
    @(negedge clk); #1;
    chk("done_width", 32'(done), 32'd0);
    chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cap_en", 32'(cap_en), 32'd0);

    // Downstream stall holding group 1 for three cycles.
    @(negedge clk); start = 1'b1; push_frame();
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_cap_en", 32'(cap_en), 32'd0);
      chk("stall_out_grp", 32'(out_grp), 32'd1);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_tw_addr", 32'(tw_addr), 32'd4);
    @(negedge clk); #1;
    chk("nobubble_valid", 32'(out_valid), 32'd1);
    chk("nobubble_grp", 32'(out_grp), 32'd2);
    wait_done();
    @(negedge clk); #1;
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

    // Start while running raises the sticky error; frame still completes.
    @(negedge clk); start = 1'b1; push_frame();
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); start = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    chk("err_set", 32'(err_start), 32'd1);
    wait_done();
    @(negedge clk); #1;
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
    chk("err_sticky", 32'(err_start), 32'd1);
    @(negedge clk); start = 1'b1; push_frame();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); start = 1'b0; err_clr = 1'b0; #1;
    chk("err_set_wins", 32'(err_start), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    chk("err_cleared", 32'(err_start), 32'd0);
    wait_done();
    @(negedge clk); #1;
    chk("frame_cnt_4", 32'(frame_cnt), 32'd4);

    // Abort with group 2 held.
    @(negedge clk); start = 1'b1; push_frame();
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); out_ready = 1'b0; abort = 1'b1; #1;
    chk("abort_held_grp", 32'(out_grp), 32'd2);
    @(negedge clk); abort = 1'b0; exp_q.delete(); #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_grp", 32'(out_grp), 32'd0);
    chk("abort_cap_en", 32'(cap_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk); #1;
    end
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd4);
    @(negedge clk); out_ready = 1'b1; start = 1'b1; push_frame();
    @(negedge clk); start = 1'b0; #1;
    chk("restart_tw_addr", 32'(tw_addr), 32'd0);
    wait_done();
    @(negedge clk); #1;
    chk("frame_cnt_5", 32'(frame_cnt), 32'd5);

    // Asynchronous reset mid-frame, with the error flag set beforehand.
    @(negedge clk); start = 1'b1; push_frame();
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("pre_rst_err", 32'(err_start), 32'd1);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_grp", 32'(out_grp), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_err_start", 32'(err_start), 32'd0);
    chk("arst_tw_addr", 32'(tw_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1; exp_q.delete();

    // Five frames back to back; the 2-bit counter wraps.
    for (int f = 1; f <= 5; f++) begin
      @(negedge clk); start = 1'b1; push_frame();
      @(negedge clk); start = 1'b0; #1;
      wait_done();
      chk("wrap_done_cap_en", 32'(cap_en2), 32'd0);
      @(negedge clk); #1;
      chk("wrap_frame_cnt2", 32'(frame_cnt2), 32'(f % 4));
      chk("wrap_frame_cnt", 32'(frame_cnt), 32'(f));
      chk("wrap_idle_cap_en", 32'(cap_en2), 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dft_stage_sched.md
Name: dft_stage_sched

Overview:
- Sequencing controller for the combinational 8-to-4 DFT butterfly stage (twiddle multiply plus radix-2 butterflies).
- Streams N_GRP input groups of one frame through the shared stage, one group per accepted handshake.
- Drives the twiddle-ROM set address for each group and the capture enable of the stage output register.
- Presents registered results downstream with valid/ready flow control, plus frame-level start/done/abort control and status.

Parameters:
- N_GRP, 4, groups per frame; must be ≥2.
- GRP_W, $clog2(N_GRP), group counter width.
- TW_AW, 4, twiddle ROM set-address width.
- TW_STEP, 2, twiddle address increment per group.
- FCNT_W, 16, completed-frame counter width.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle frame start request.
- abort, in, 1, synchronous frame abort.
- in_valid, in, 1, input group present at the stage inputs.
- in_ready, out, 1, group accepted this cycle when in_valid is also high.
- tw_addr, out, TW_AW, twiddle set address for the group currently at the stage inputs.
- cap_en, out, 1, load enable for the stage output register; equals in_valid & in_ready.
- out_valid, out, 1, stage output register holds a valid group.
- out_ready, in, 1, downstream accepts the group.
- out_grp, out, GRP_W, group index of the held output.
- out_last, out, 1, held output is the last group of the frame.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse after the last group is transferred downstream.
- frame_cnt, out, FCNT_W, completed frames; wraps.
- err_start, out, 1, sticky flag: start was received while busy.
- err_clr, in, 1, clears err_start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, grp_cnt=0.
  - in_ready=0, cap_en=0, out_valid=0, out_grp=0, out_last=0.
  - tw_addr=0, busy=0, done=0, frame_cnt=0, err_start=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start → RUN, grp_cnt←0.
- RUN:
  - in_ready = (grp_cnt < N_GRP) & (!out_valid | out_ready). Combinational from registered state and out_ready.
  - tw_addr = (grp_cnt*TW_STEP) mod 2^TW_AW. Combinational; valid whenever state==RUN, otherwise 0.
  - On accept (in_valid & in_ready):
    - out_valid←1, out_grp←grp_cnt, out_last←(grp_cnt==N_GRP-1), grp_cnt←grp_cnt+1.
    - If grp_cnt==N_GRP-1 → DRAIN.
  - An output transfer and a new accept in the same cycle are allowed; the register reloads with no bubble, giving full throughput of one group per cycle.
- Output register:
  - Latency from accept to out_valid is 1 cycle.
  - On out_valid & out_ready with no new accept → out_valid←0.
  - out_grp and out_last hold while out_valid & !out_ready.
- DRAIN:
  - in_ready=0.
  - When out_valid & out_ready & out_last → DONE, out_valid←0.
- DONE:
  - done=1 for exactly this cycle, frame_cnt←frame_cnt+1.
  - → IDLE. A start in this cycle is ignored and sets err_start.
- start:
  - In any state other than IDLE, start is ignored and err_start←1.
  - err_clr clears err_start. If err_clr and a new error occur in the same cycle, the set wins.
- abort:
  - In any state, abort → IDLE next cycle, clearing grp_cnt, out_valid, out_last and out_grp.
  - No done pulse and frame_cnt is unchanged.
  - abort has priority over start, accept and transfer in the same cycle.
- Reset mid-frame behaves like abort but also clears frame_cnt and err_start.
- in_valid is ignored outside RUN and never causes cap_en.
- frame_cnt wraps from 2^FCNT_W-1 to 0.

Test Plan:
- Reset, then start with in_valid=1 and out_ready=1 held (N_GRP=4, TW_STEP=2):
  - tw_addr=0,2,4,6 on consecutive cycles.
  - out_grp=0..3 one cycle later; out_last only with grp 3.
  - done pulses 1 cycle after the grp-3 transfer; frame_cnt=1.
- out_ready low for 3 cycles while out_grp=1 is held:
  - in_ready=0 and cap_en=0 during the stall.
  - out_grp=1 is stable for the whole stall.
  - After release, grp 2 is accepted in the same cycle grp 1 transfers; there is no bubble.
- Start pulsed during RUN:
  - Frame completes normally.
  - err_start=1 and stays set until err_clr; err_clr plus a coincident start leaves err_start=1.
- Abort asserted while out_valid=1 with grp 2 held:
  - Next cycle state=IDLE, out_valid=0, in_ready=0.
  - No done pulse; frame_cnt unchanged.
  - A subsequent start runs a full frame from grp 0.
- rst_n pulled low mid-RUN, asynchronously between clock edges:
  - All outputs go to reset values immediately.
  - frame_cnt=0 and err_start=0.
- FCNT_W=2, run 5 frames back-to-back:
  - frame_cnt steps 1,2,3,0,1.
  - in_valid asserted in IDLE/DONE never produces cap_en.
